// File: rtl/mem_bridge_pkg.sv
// Shared types for the sram-like bridge: channel FSM states, access sizes,
// and the store byte-enable to size/address mapping.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] addr_lo;
    } size_addr_t;

    // An illegal mask issues a word access and keeps the core's low address bits.
    function automatic size_addr_t wen_to_size_addr(input logic [3:0] wen,
                                                    input logic [1:0] addr_lo);
        size_addr_t r;
        r.size    = SZ_W;
        r.addr_lo = addr_lo;
        case (wen)
            4'b1111: r.addr_lo = 2'b00;
            4'b0011: begin r.size = SZ_H; r.addr_lo = 2'b00; end
            4'b1100: begin r.size = SZ_H; r.addr_lo = 2'b10; end
            4'b0001: begin r.size = SZ_B; r.addr_lo = 2'b00; end
            4'b0010: begin r.size = SZ_B; r.addr_lo = 2'b01; end
            4'b0100: begin r.size = SZ_B; r.addr_lo = 2'b10; end
            4'b1000: begin r.size = SZ_B; r.addr_lo = 2'b11; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_like_channel.sv
// One sram-like request/response channel: captures the core's request,
// drives req until addr_ok, then holds the response until the pipeline moves.
module sram_like_channel
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              wr_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output state_e            state_o,
    output logic [DATA_W-1:0] result_o,
    output logic              req_o,
    output logic              wr_o,
    output logic [1:0]        size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i
);

    state_e            state_q;
    logic              req_q;
    logic              discard_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_i && !flush_i) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        wr_q    <= wr_i;
                        size_q  <= size_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                    end
                end
                ST_REQ: begin
                    // An accepted request cannot be withdrawn; a flush only marks it for discard.
                    if (flush_i) discard_q <= 1'b1;
                    if (addr_ok_i) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (data_ok_i) begin
                        if (discard_q || flush_i) begin
                            state_q   <= ST_IDLE;
                            discard_q <= 1'b0;
                        end else begin
                            state_q  <= ST_DONE;
                            result_q <= rdata_i;
                        end
                    end else if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush_i || !stall_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                      ((state_q == ST_IDLE) && en_i);
    assign state_o  = state_q;
    assign result_o = result_q;
    assign req_o    = req_q;
    assign wr_o     = wr_q;
    assign size_o   = size_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;

endmodule

// File: rtl/sram_like_mem_bridge.sv
// Bridges the core's single-cycle inst/data SRAM ports onto two sram-like
// channels and freezes the pipeline while either access is in flight.
module sram_like_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inst_en_i,
    output logic [DATA_W-1:0] instr_o,
    input  logic              data_en_i,
    input  logic              data_wr_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [3:0]        data_wen_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    input  logic              flush_i,
    output logic              stall_o,
    output state_e            inst_state_o,
    output state_e            data_state_o,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    logic              inst_busy;
    logic              data_busy;
    size_addr_t        st_map;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;

    // Loads are always word-aligned words; the core extracts bytes/halves itself.
    always_comb begin
        st_map = wen_to_size_addr(data_wen_i, data_addr_i[1:0]);
        d_size = SZ_W;
        d_addr = {data_addr_i[ADDR_W-1:2], 2'b00};
        if (data_wr_i) begin
            d_size = st_map.size;
            d_addr = {data_addr_i[ADDR_W-1:2], st_map.addr_lo};
        end
    end

    assign stall_o = inst_busy | data_busy;

    sram_like_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst (
        .clk      (clk),
        .rst      (rst),
        .en_i     (inst_en_i),
        .flush_i  (flush_i),
        .stall_i  (stall_o),
        .wr_i     (1'b0),
        .size_i   (SZ_W),
        .addr_i   (pc_i),
        .wdata_i  ('0),
        .busy_o   (inst_busy),
        .state_o  (inst_state_o),
        .result_o (instr_o),
        .req_o    (inst_req),
        .wr_o     (inst_wr),
        .size_o   (inst_size),
        .addr_o   (inst_addr),
        .wdata_o  (inst_wdata),
        .addr_ok_i(inst_addr_ok),
        .data_ok_i(inst_data_ok),
        .rdata_i  (inst_rdata)
    );

    sram_like_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data (
        .clk      (clk),
        .rst      (rst),
        .en_i     (data_en_i),
        .flush_i  (flush_i),
        .stall_i  (stall_o),
        .wr_i     (data_wr_i),
        .size_i   (d_size),
        .addr_i   (d_addr),
        .wdata_i  (data_wdata_i),
        .busy_o   (data_busy),
        .state_o  (data_state_o),
        .result_o (data_rdata_o),
        .req_o    (data_req),
        .wr_o     (data_wr),
        .size_o   (data_size),
        .addr_o   (data_addr),
        .wdata_o  (data_wdata),
        .addr_ok_i(data_addr_ok),
        .data_ok_i(data_data_ok),
        .rdata_i  (data_rdata)
    );

endmodule

// File: tb/tb_sram_like_mem_bridge.sv
// Directed bench for sram_like_mem_bridge: the core side and both slaves are
// driven cycle by cycle from hand-written sequences with hand-computed results.
module tb_sram_like_mem_bridge;
    import mem_bridge_pkg::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        inst_en_i;
    logic [31:0] instr_o;
    logic        data_en_i;
    logic        data_wr_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_wen_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        flush_i;
    logic        stall_o;
    state_e      inst_state_o;
    state_e      data_state_o;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    sram_like_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .inst_en_i(inst_en_i), .instr_o(instr_o),
        .data_en_i(data_en_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
        .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .flush_i(flush_i), .stall_o(stall_o),
        .inst_state_o(inst_state_o), .data_state_o(data_state_o),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc_i = '0; inst_en_i = 0; data_en_i = 0; data_wr_i = 0; data_addr_i = '0;
        data_wen_i = '0; data_wdata_i = '0; flush_i = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    endtask

    // One data access with addr_ok at +1 and data_ok at +2.
    task automatic do_data_access(input string tag, input logic wr, input logic [3:0] wen,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input logic [1:0] exp_size,
                                  input logic [31:0] exp_addr);
        if (wr) begin
            assert (wen inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000})
                else $error("illegal store byte mask %b", wen);
        end
        tick();
        data_en_i = 1; data_wr_i = wr; data_wen_i = wen; data_addr_i = addr; data_wdata_i = wdata;
        sample();
        check_eq({tag, "_stall_idle"}, stall_o, 1);
        tick();
        // Core-side values scrambled: request fields must come from the capture registers.
        data_addr_i = ~addr; data_wdata_i = ~wdata; data_wen_i = 4'b1111; data_addr_ok = 1;
        sample();
        check_eq({tag, "_req"}, data_req, 1);
        check_eq({tag, "_wr"}, data_wr, wr);
        check_eq({tag, "_size"}, data_size, exp_size);
        check_eq({tag, "_addr"}, data_addr, exp_addr);
        check_eq({tag, "_wdata"}, data_wdata, wdata);
        tick();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = rdata;
        exp_q.push_back(rdata);
        sample();
        check_eq({tag, "_req_wait"}, data_req, 0);
        tick();
        data_data_ok = 0;
        sample();
        exp_v = exp_q.pop_front();
        check_eq({tag, "_done_state"}, data_state_o, S_DONE);
        check_eq({tag, "_done_stall"}, stall_o, 0);
        check_eq({tag, "_result"}, data_rdata_o, exp_v);
        tick();
        data_en_i = 0; data_wr_i = 0;
        sample();
        check_eq({tag, "_back_idle"}, data_state_o, S_IDLE);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        sample();
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_inst_req", inst_req, 0);
        check_eq("rst_data_req", data_req, 0);
        check_eq("rst_instr", instr_o, 0);
        check_eq("rst_rdata", data_rdata_o, 0);
        check_eq("rst_states", {inst_state_o, data_state_o}, 4'b0000);
        tick();
        rst = 0;

        // Single fetch: req for exactly one cycle, stall for three.
        tick();
        inst_en_i = 1; pc_i = 32'hBFC0_0000;
        sample();
        check_eq("f_c0_stall", stall_o, 1);
        check_eq("f_c0_req", inst_req, 0);
        tick();
        inst_addr_ok = 1;
        sample();
        check_eq("f_c1_req", inst_req, 1);
        check_eq("f_c1_addr", inst_addr, 32'hBFC0_0000);
        check_eq("f_c1_size", inst_size, 2'd2);
        check_eq("f_c1_wr", inst_wr, 0);
        check_eq("f_c1_wdata", inst_wdata, 0);
        check_eq("f_c1_stall", stall_o, 1);
        tick();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3C08_0001;
        sample();
        check_eq("f_c2_req", inst_req, 0);
        check_eq("f_c2_stall", stall_o, 1);
        tick();
        inst_data_ok = 0;
        sample();
        check_eq("f_c3_state", inst_state_o, S_DONE);
        check_eq("f_c3_stall", stall_o, 0);
        check_eq("f_c3_instr", instr_o, 32'h3C08_0001);
        check_eq("f_c3_req", inst_req, 0);
        tick();
        inst_en_i = 0;
        sample();
        check_eq("f_c4_state", inst_state_o, S_IDLE);
        check_eq("f_c4_instr", instr_o, 32'h3C08_0001);

        // Store/load mapping table; first row is the byte store at 0x80000013.
        do_data_access("st_b2",  1, 4'b0100, 32'h8000_0013, 32'h00AB_0000, 32'h0000_0000, 2'd0, 32'h8000_0012);
        do_data_access("st_w",   1, 4'b1111, 32'h8000_0013, 32'h1234_5678, 32'h0000_0011, 2'd2, 32'h8000_0010);
        do_data_access("st_hlo", 1, 4'b0011, 32'h8000_0002, 32'h0000_BEEF, 32'h0000_0022, 2'd1, 32'h8000_0000);
        do_data_access("st_hhi", 1, 4'b1100, 32'h8000_0001, 32'hBEEF_0000, 32'h0000_0033, 2'd1, 32'h8000_0002);
        do_data_access("st_b0",  1, 4'b0001, 32'h8000_0003, 32'h0000_00AA, 32'h0000_0044, 2'd0, 32'h8000_0000);
        do_data_access("st_b1",  1, 4'b0010, 32'h8000_0003, 32'h0000_AA00, 32'h0000_0055, 2'd0, 32'h8000_0001);
        do_data_access("st_b3",  1, 4'b1000, 32'h8000_0000, 32'hAA00_0000, 32'h0000_0066, 2'd0, 32'h8000_0003);
        do_data_access("ld_w",   0, 4'b0000, 32'h8000_0007, 32'h0000_0000, 32'hCAFE_F00D, 2'd2, 32'h8000_0004);

        // Fetch and load together; the fetch finishes first and is held.
        tick();
        inst_en_i = 1; pc_i = 32'hBFC0_0004;
        data_en_i = 1; data_wr_i = 0; data_addr_i = 32'h8000_0100;
        sample();
        check_eq("fl_c0_stall", stall_o, 1);
        tick();
        inst_addr_ok = 1; data_addr_ok = 1;
        sample();
        check_eq("fl_c1_reqs", {inst_req, data_req}, 2'b11);
        tick();
        inst_addr_ok = 0; data_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h1111_1111;
        sample();
        check_eq("fl_c2_stall", stall_o, 1);
        for (int c = 3; c <= 6; c++) begin
            tick();
            inst_data_ok = 0;
            if (c == 6) begin
                data_data_ok = 1; data_rdata = 32'h2222_2222;
            end
            sample();
            check_eq($sformatf("fl_c%0d_instr", c), instr_o, 32'h1111_1111);
            check_eq($sformatf("fl_c%0d_istate", c), inst_state_o, S_DONE);
            check_eq($sformatf("fl_c%0d_stall", c), stall_o, 1);
        end
        tick();
        data_data_ok = 0;
        sample();
        check_eq("fl_c7_stall", stall_o, 0);
        check_eq("fl_c7_rdata", data_rdata_o, 32'h2222_2222);
        check_eq("fl_c7_instr", instr_o, 32'h1111_1111);
        tick();
        inst_en_i = 0; data_en_i = 0;
        sample();
        check_eq("fl_c8_states", {inst_state_o, data_state_o}, 4'b0000);

        // addr_ok withheld for five cycles: request must not move or repeat.
        tick();
        inst_en_i = 1; pc_i = 32'h0040_0000;
        sample();
        for (int c = 1; c <= 5; c++) begin
            tick();
            pc_i = 32'h0040_0000 + 32'(c * 4);
            sample();
            check_eq($sformatf("ao_c%0d_req", c), inst_req, 1);
            check_eq($sformatf("ao_c%0d_addr", c), inst_addr, 32'h0040_0000);
            check_eq($sformatf("ao_c%0d_size", c), inst_size, 2'd2);
        end
        tick();
        pc_i = 32'h0040_0000; inst_addr_ok = 1;
        sample();
        check_eq("ao_c6_req", inst_req, 1);
        tick();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h0000_0005;
        sample();
        check_eq("ao_c7_req", inst_req, 0);
        tick();
        inst_data_ok = 0;
        sample();
        check_eq("ao_c8_instr", instr_o, 32'h0000_0005);
        check_eq("ao_c8_req", inst_req, 0);
        tick();
        inst_en_i = 0;
        sample();

        // Flush during WAIT: drain to data_ok, drop the data, end in IDLE.
        tick();
        data_en_i = 1; data_wr_i = 0; data_addr_i = 32'h8000_1000;
        sample();
        tick();
        data_addr_ok = 1;
        sample();
        tick();
        data_addr_ok = 0; flush_i = 1; data_en_i = 0;
        sample();
        check_eq("fw_c2_state", data_state_o, S_WAIT);
        check_eq("fw_c2_stall", stall_o, 1);
        tick();
        flush_i = 0;
        sample();
        check_eq("fw_c3_stall", stall_o, 1);
        tick();
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        sample();
        check_eq("fw_c4_stall", stall_o, 1);
        tick();
        data_data_ok = 0;
        sample();
        check_eq("fw_c5_state", data_state_o, S_IDLE);
        check_eq("fw_c5_rdata", data_rdata_o, 32'h2222_2222);
        check_eq("fw_c5_stall", stall_o, 0);

        // Asynchronous reset while a fetch is in REQ.
        tick();
        inst_en_i = 1; pc_i = 32'hBFC0_0100;
        sample();
        tick();
        sample();
        check_eq("ar_req_before", inst_req, 1);
        @(posedge clk);
        #2;
        rst = 1; inst_en_i = 0;
        #1;
        check_eq("ar_req", inst_req, 0);
        check_eq("ar_stall", stall_o, 0);
        check_eq("ar_instr", instr_o, 0);
        check_eq("ar_rdata", data_rdata_o, 0);
        check_eq("ar_state", inst_state_o, S_IDLE);
        tick();
        rst = 0;
        tick();
        sample();
        check_eq("ar_after_req", inst_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
